// File: rtl/riscv_pkg.sv
// Shared RV32 constants: widths, the canonical NOP and the decode field positions.
package riscv_pkg;

  localparam int unsigned RV_XLEN     = 32;
  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  localparam int unsigned OP_LSB = 0;
  localparam int unsigned F3_LSB = 12;
  localparam int unsigned F7_LSB = 25;

  function automatic logic [6:0] get_op(input logic [31:0] word);
    return word[OP_LSB +: 7];
  endfunction

  function automatic logic [2:0] get_funct3(input logic [31:0] word);
    return word[F3_LSB +: 3];
  endfunction

  function automatic logic [6:0] get_funct7(input logic [31:0] word);
    return word[F7_LSB +: 7];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {instr, pc} pairs; push into a full queue is
// accepted when a pop happens in the same cycle.
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32 fetch stage: owns the PC, issues credit-limited in-order memory requests, buffers
// responses and presents the head instruction (with decoded fields) to decode.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = RV_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RV_RESET_PC),
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  in_flight_q, in_flight_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic [CNT_W:0]    credits_used;
  logic              req_fire, rsp_keep, q_pop;
  logic [XLEN-1:0]   rsp_pc;
  logic [2*XLEN-1:0] q_head;
  logic [CNT_W-1:0]  q_count;
  logic              q_full, q_empty;

  assign credits_used   = {1'b0, in_flight_q} + {1'b0, q_count};
  assign imem_req_valid = !rst && !redirect_valid && (credits_used < (CNT_W + 1)'(DEPTH));
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // With nothing to discard, every outstanding request is contiguous and ends at pc_q,
  // so the oldest one (the one answering now) sits in_flight words behind it.
  assign rsp_pc   = pc_q - (XLEN'(in_flight_q) << 2);
  assign rsp_keep = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
  assign q_pop    = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    in_flight_d = in_flight_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    discard_d   = discard_q;
    pc_d        = pc_q;
    if (redirect_valid) begin
      discard_d = in_flight_d;
      pc_d      = {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - 1'b1;
      if (req_fire) pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      in_flight_q <= '0;
      discard_q   <= '0;
    end else begin
      pc_q        <= pc_d;
      in_flight_q <= in_flight_d;
      discard_q   <= discard_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({imem_rdata, rsp_pc}),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign instr_valid = !q_empty;
  assign instr       = q_empty ? XLEN'(NOP_INSTR) : q_head[2*XLEN-1:XLEN];
  assign instr_pc    = q_empty ? '0 : q_head[XLEN-1:0];
  assign op          = get_op(instr[31:0]);
  assign funct3      = get_funct3(instr[31:0]);
  assign funct7      = get_funct7(instr[31:0]);

  // Credits guarantee a free slot for every response; a word arriving into a full queue
  // means memory broke the request/response protocol.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(imem_rsp_valid && q_full));
  end

endmodule
